// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO stream reader and its companion FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data presents the head word whenever empty is low.
module sync_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_wr;
  logic                  do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a requested number of words from a show-ahead FIFO and streams them out
// through a single valid/ready register stage at up to one word per cycle.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  reader_state_t        state;
  reader_state_t        state_nxt;
  logic [LEN_WIDTH-1:0] pop_cnt;
  logic [LEN_WIDTH-1:0] acc_cnt;
  logic                 load;
  logic                 hs;

  // Load whenever the output stage is empty or being drained this cycle.
  assign load      = (state == RUN) && (pop_cnt != '0) && !fifo_empty && (!m_valid || m_ready);
  assign hs        = m_valid && m_ready;
  assign fifo_rden = load;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? FINISH : RUN;
      end
      RUN: begin
        if (hs && (acc_cnt == LEN_WIDTH'(1))) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_cnt <= '0;
      acc_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        pop_cnt <= len;
        acc_cnt <= len;
      end else begin
        if (load) pop_cnt <= pop_cnt - 1'b1;
        if (hs && (acc_cnt != '0)) acc_cnt <= acc_cnt - 1'b1;
      end

      if (load) begin
        m_valid <= 1'b1;
        m_data  <= fifo_data;
      end else if (hs) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
